md_issuer: RTL and testbench



---
 rtl/md_issuer_pkg.sv | 44 ++++
 rtl/md_issuer_if.sv | 38 +++
 rtl/md_issuer.sv | 112 +++++++++++
 tb/tb_md_issuer.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/md_issuer_pkg.sv
// Shared types for the multiply/divide issuer: op encoding, FSM states and
// the held-request payload.
package md_issuer_pkg;

  localparam int unsigned OP_W   = 4;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned REG_W  = 5;

  typedef enum logic [OP_W-1:0] {
    MD_NONE  = 4'd0,
    MD_MULT  = 4'd1,
    MD_MULTU = 4'd2,
    MD_DIV   = 4'd3,
    MD_DIVU  = 4'd4,
    MD_MFHI  = 4'd5,
    MD_MFLO  = 4'd6,
    MD_MTHI  = 4'd7,
    MD_MTLO  = 4'd8
  } md_op_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WAIT  = 2'd1,
    ST_ISSUE = 2'd2
  } state_e;

  typedef struct packed {
    md_op_e              op;
    logic [DATA_W-1:0]   rs;
    logic [DATA_W-1:0]   rt;
    logic [REG_W-1:0]    dst;
  } md_req_t;

  // Ops that read hi/lo back and therefore produce a writeback
  function automatic logic is_mf(md_op_e op);
    return (op == MD_MFHI) || (op == MD_MFLO);
  endfunction

  // Ops that start a multi-cycle operation in the unit
  function automatic logic is_start(md_op_e op);
    return op inside {MD_MULT, MD_MULTU, MD_DIV, MD_DIVU};
  endfunction

endpackage

// File: rtl/md_issuer_if.sv
// Request, MD-unit and writeback signals of the issuer, bundled with the
// issuer-side (slave) and environment-side (master) views.
interface md_issuer_if;
  import md_issuer_pkg::*;

  logic              req_valid;
  md_op_e            req_op;
  logic [DATA_W-1:0] req_rs;
  logic [DATA_W-1:0] req_rt;
  logic [REG_W-1:0]  req_dst;
  logic              req_ready;
  logic              flush;

  md_op_e            md_op;
  logic [DATA_W-1:0] md_rs;
  logic [DATA_W-1:0] md_rt;
  logic              md_busy;
  logic [DATA_W-1:0] md_out;

  logic              stall;
  logic              wb_valid;
  logic [REG_W-1:0]  wb_dst;
  logic [DATA_W-1:0] wb_data;
  logic              protocol_err;

  modport slave (
    input  req_valid, req_op, req_rs, req_rt, req_dst, flush, md_busy, md_out,
    output req_ready, md_op, md_rs, md_rt, stall, wb_valid, wb_dst, wb_data,
           protocol_err
  );

  modport master (
    output req_valid, req_op, req_rs, req_rt, req_dst, flush, md_busy, md_out,
    input  req_ready, md_op, md_rs, md_rt, stall, wb_valid, wb_dst, wb_data,
           protocol_err
  );

endinterface

// File: rtl/md_issuer.sv
// Initiator-side controller for the E-stage multiply/divide unit. md_op is
// driven purely from registers so it never depends combinationally on md_busy.
module md_issuer
  import md_issuer_pkg::*;
#(
  parameter int unsigned MULT_LAT = 5,
  parameter int unsigned DIV_LAT  = 10,
  parameter int unsigned WD_LIMIT = ((DIV_LAT > MULT_LAT) ? DIV_LAT : MULT_LAT) + 4
) (
  input  logic        clk,
  input  logic        rst_n,
  md_issuer_if.slave  bus
);

  localparam int unsigned WD_W = $clog2(WD_LIMIT + 1);

  state_e            state_q, state_d;
  md_req_t           held_q, held_d;
  md_op_e            op_q, op_d;
  logic              ready_q, ready_d;
  logic              wb_valid_q, wb_valid_d;
  logic [REG_W-1:0]  wb_dst_q, wb_dst_d;
  logic [DATA_W-1:0] wb_data_q, wb_data_d;
  logic [WD_W-1:0]   wd_q, wd_d;
  logic              perr_q, perr_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Next state plus the next value of every registered output
  always_comb begin
    state_d    = state_q;
    held_d     = held_q;
    op_d       = MD_NONE;
    wb_valid_d = 1'b0;
    wb_dst_d   = wb_dst_q;
    wb_data_d  = wb_data_q;
    wd_d       = wd_q;
    perr_d     = perr_q;

    unique case (state_q)
      ST_IDLE: begin
        if (bus.req_valid && (bus.req_op != MD_NONE)) begin
          held_d.op  = bus.req_op;
          held_d.rs  = bus.req_rs;
          held_d.rt  = bus.req_rt;
          held_d.dst = bus.req_dst;
          wd_d       = '0;
          state_d    = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (bus.flush) begin
          state_d = ST_IDLE;
        end else if (!bus.md_busy) begin
          op_d    = held_q.op;
          state_d = ST_ISSUE;
        end else begin
          // Saturating watchdog; the flag is sticky until reset
          if (wd_q != WD_W'(WD_LIMIT)) wd_d = wd_q + WD_W'(1);
          if (wd_q == WD_W'(WD_LIMIT - 1)) perr_d = 1'b1;
        end
      end
      ST_ISSUE: begin
        state_d = ST_IDLE;
        if (is_mf(held_q.op)) begin
          wb_valid_d = 1'b1;
          wb_data_d  = bus.md_out;
          wb_dst_d   = held_q.dst;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    ready_d = (state_d == ST_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      held_q     <= '0;
      op_q       <= MD_NONE;
      ready_q    <= 1'b1;
      wb_valid_q <= 1'b0;
      wb_dst_q   <= '0;
      wb_data_q  <= '0;
      wd_q       <= '0;
      perr_q     <= 1'b0;
    end else begin
      held_q     <= held_d;
      op_q       <= op_d;
      ready_q    <= ready_d;
      wb_valid_q <= wb_valid_d;
      wb_dst_q   <= wb_dst_d;
      wb_data_q  <= wb_data_d;
      wd_q       <= wd_d;
      perr_q     <= perr_d;
    end
  end

  assign bus.req_ready    = ready_q;
  assign bus.md_op        = op_q;
  assign bus.md_rs        = held_q.rs;
  assign bus.md_rt        = held_q.rt;
  assign bus.wb_valid     = wb_valid_q;
  assign bus.wb_dst       = wb_dst_q;
  assign bus.wb_data      = wb_data_q;
  assign bus.protocol_err = perr_q;
  assign bus.stall        = (state_q != ST_IDLE) | bus.md_busy;

endmodule

// File: tb/tb_md_issuer.sv
// Randomized bench for md_issuer: a behavioural MD unit drives busy/out, and
// a program-order hi/lo model predicts every issue and writeback.
module tb_md_issuer;
  import md_issuer_pkg::*;

  localparam int unsigned MULT_LAT = 5;
  localparam int unsigned DIV_LAT  = 10;
  localparam int unsigned WD_LIMIT = DIV_LAT + 4;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  md_issuer_if bus ();

  md_issuer #(.MULT_LAT(MULT_LAT), .DIV_LAT(DIV_LAT), .WD_LIMIT(WD_LIMIT)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct { md_op_e op; logic [31:0] rs; logic [31:0] rt; } iss_t;
  typedef struct { logic [4:0] dst; logic [31:0] data; } wb_t;

  int n_checks = 0;
  int n_err    = 0;
  int cyc      = 0;
  int wb_seen  = 0;
  int last_wb_cyc = 0;
  int issue_log[$];
  iss_t exp_iss[$];
  wb_t  exp_wb[$];
  iss_t mon_iss;
  wb_t  mon_wb;
  logic [31:0] ref_hi = '0, ref_lo = '0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] md_math(md_op_e op, logic [31:0] rs, logic [31:0] rt,
                                          logic [31:0] hi, logic [31:0] lo);
    longint sa, sb;
    logic [63:0] r;
    sa = longint'($signed(rs));
    sb = longint'($signed(rt));
    r  = {hi, lo};
    case (op)
      MD_MULT:  r = 64'(sa * sb);
      MD_MULTU: r = {32'h0, rs} * {32'h0, rt};
      MD_DIV:   r = {32'(sa % sb), 32'(sa / sb)};
      MD_DIVU:  r = {rs % rt, rs / rt};
      MD_MTHI:  r = {rs, lo};
      MD_MTLO:  r = {hi, rs};
      default:  ;
    endcase
    return r;
  endfunction

  // Behavioural MD unit: samples md_op each edge, busy for the op latency
  logic [31:0] u_hi = '0, u_lo = '0;
  int   unit_cnt = 0;
  logic force_busy;
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (unit_cnt != 0) unit_cnt <= unit_cnt - 1;
    if (bus.md_op != MD_NONE) begin
      {u_hi, u_lo} <= md_math(bus.md_op, bus.md_rs, bus.md_rt, u_hi, u_lo);
      if (bus.md_op inside {MD_MULT, MD_MULTU}) unit_cnt <= MULT_LAT;
      else if (bus.md_op inside {MD_DIV, MD_DIVU}) unit_cnt <= DIV_LAT;
    end
  end
  assign bus.md_busy = (unit_cnt != 0) || force_busy;
  assign bus.md_out  = (bus.md_op == MD_MFHI) ? u_hi :
                       (bus.md_op == MD_MFLO) ? u_lo : 32'h0;

  // Monitor: every issue and writeback is matched against the model queues
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.md_op != MD_NONE) begin
        issue_log.push_back(cyc);
        chk("issue_while_busy", 64'((unit_cnt != 0) || force_busy), 64'(0));
        if (exp_iss.size() == 0) begin
          chk("unexpected_issue", 64'(bus.md_op), 64'(MD_NONE));
        end else begin
          mon_iss = exp_iss.pop_front();
          chk("issue_op", 64'(bus.md_op), 64'(mon_iss.op));
          chk("issue_rs", 64'(bus.md_rs), 64'(mon_iss.rs));
          chk("issue_rt", 64'(bus.md_rt), 64'(mon_iss.rt));
        end
      end
      if (bus.wb_valid) begin
        wb_seen++;
        last_wb_cyc = cyc;
        if (exp_wb.size() == 0) begin
          chk("unexpected_wb", 64'(bus.wb_valid), 64'(0));
        end else begin
          mon_wb = exp_wb.pop_front();
          chk("wb_dst", 64'(bus.wb_dst), 64'(mon_wb.dst));
          chk("wb_data", 64'(bus.wb_data), 64'(mon_wb.data));
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic apply_ref(input md_op_e op, input logic [31:0] rs, input logic [31:0] rt,
                           input logic [4:0] dst);
    iss_t i;
    wb_t  w;
    i.op = op; i.rs = rs; i.rt = rt;
    exp_iss.push_back(i);
    if (is_mf(op)) begin
      w.dst  = dst;
      w.data = (op == MD_MFHI) ? ref_hi : ref_lo;
      exp_wb.push_back(w);
    end else begin
      {ref_hi, ref_lo} = md_math(op, rs, rt, ref_hi, ref_lo);
    end
  endtask

  task automatic accept(input md_op_e op, input logic [31:0] rs, input logic [31:0] rt,
                        input logic [4:0] dst, output int acc);
    int n;
    n = 0;
    bus.req_valid = 1'b1; bus.req_op = op;
    bus.req_rs = rs; bus.req_rt = rt; bus.req_dst = dst;
    while (!bus.req_ready && n < 200) begin
      tick(1);
      n++;
    end
    chk("accept_timeout", 64'(bus.req_ready), 64'(1));
    tick(1);
    acc = cyc;
    bus.req_valid = 1'b0; bus.req_op = MD_NONE;
  endtask

  task automatic send(input md_op_e op, input logic [31:0] rs, input logic [31:0] rt,
                      input logic [4:0] dst, input bit fl, output int acc);
    accept(op, rs, rt, dst, acc);
    if (fl) begin
      bus.flush = 1'b1;
      tick(1);
      bus.flush = 1'b0;
    end else begin
      apply_ref(op, rs, rt, dst);
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((exp_iss.size() != 0 || exp_wb.size() != 0) && n < 300) begin
      tick(1);
      n++;
    end
    chk("drain_iss", 64'(exp_iss.size()), 64'(0));
    chk("drain_wb", 64'(exp_wb.size()), 64'(0));
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    tick(1);
  endtask

  initial begin
    int a0, a1, n0, w0;
    md_op_e op;
    logic [31:0] rs, rt;

    rst_n = 1'b0; force_busy = 1'b0; bus.flush = 1'b0;
    bus.req_valid = 1'b0; bus.req_op = MD_NONE;
    bus.req_rs = '0; bus.req_rt = '0; bus.req_dst = '0;
    tick(2);
    chk("rst_ready", 64'(bus.req_ready), 64'(1));
    chk("rst_md_op", 64'(bus.md_op), 64'(MD_NONE));
    chk("rst_md_rs", 64'(bus.md_rs), 64'(0));
    chk("rst_wb_valid", 64'(bus.wb_valid), 64'(0));
    chk("rst_wb_data", 64'(bus.wb_data), 64'(0));
    chk("rst_wb_dst", 64'(bus.wb_dst), 64'(0));
    chk("rst_perr", 64'(bus.protocol_err), 64'(0));
    chk("rst_stall", 64'(bus.stall), 64'(0));
    rst_n = 1'b1;
    tick(1);

    // Mthi then Mfhi: minimum latency and spacing
    issue_log.delete();
    send(MD_MTHI, 32'h1234_5678, 32'h0, 5'd0, 1'b0, a0);
    send(MD_MFHI, 32'h0, 32'h0, 5'd8, 1'b0, a1);
    drain();
    chk("req_spacing", 64'(a1 - a0), 64'(3));
    chk("mthi_issue_lat", 64'(issue_log[0] - a0), 64'(1));
    chk("mfhi_issue_lat", 64'(issue_log[1] - a1), 64'(1));
    chk("mfhi_wb_lat", 64'(last_wb_cyc - a1), 64'(2));
    chk("mfhi_wb_dst", 64'(bus.wb_dst), 64'(8));
    chk("mfhi_wb_data", 64'(bus.wb_data), 64'(32'h1234_5678));

    // Mult -3*7 then Mflo waits out the busy window
    issue_log.delete();
    send(MD_MULT, 32'hFFFF_FFFD, 32'd7, 5'd0, 1'b0, a0);
    send(MD_MFLO, 32'h0, 32'h0, 5'd2, 1'b0, a1);
    chk("mflo_wait_stall", 64'(bus.stall), 64'(1));
    chk("mflo_wait_ready", 64'(bus.req_ready), 64'(0));
    drain();
    chk("mflo_after_busy", 64'(issue_log[1] - issue_log[0]), 64'(MULT_LAT + 2));
    chk("mflo_wb_data", 64'(bus.wb_data), 64'(32'hFFFF_FFEB));
    chk("mflo_wb_dst", 64'(bus.wb_dst), 64'(2));

    // Div 100/7 then Mfhi returns the remainder
    issue_log.delete();
    send(MD_DIV, 32'd100, 32'd7, 5'd0, 1'b0, a0);
    send(MD_MFHI, 32'h0, 32'h0, 5'd5, 1'b0, a1);
    drain();
    chk("div_after_busy", 64'(issue_log[1] - issue_log[0]), 64'(DIV_LAT + 2));
    chk("div_wb_data", 64'(bus.wb_data), 64'(2));
    chk("div_perr", 64'(bus.protocol_err), 64'(0));

    // Flush while held in WAIT discards the request
    n0 = issue_log.size(); w0 = wb_seen;
    force_busy = 1'b1;
    accept(MD_MFHI, 32'h1, 32'h2, 5'd9, a0);
    tick(3);
    chk("wait_ready", 64'(bus.req_ready), 64'(0));
    chk("wait_stall", 64'(bus.stall), 64'(1));
    chk("wait_md_op", 64'(bus.md_op), 64'(MD_NONE));
    bus.flush = 1'b1;
    tick(1);
    bus.flush = 1'b0;
    force_busy = 1'b0;
    chk("flush_ready", 64'(bus.req_ready), 64'(1));
    tick(4);
    chk("flush_no_issue", 64'(issue_log.size()), 64'(n0));
    chk("flush_no_wb", 64'(wb_seen), 64'(w0));
    chk("flush_perr", 64'(bus.protocol_err), 64'(0));

    // Watchdog: sticky error after WD_LIMIT busy WAIT cycles
    force_busy = 1'b1;
    accept(MD_MTLO, 32'hCAFE_F00D, 32'h0, 5'd0, a0);
    apply_ref(MD_MTLO, 32'hCAFE_F00D, 32'h0, 5'd0);
    tick(WD_LIMIT - 1);
    chk("wd_below_limit", 64'(bus.protocol_err), 64'(0));
    tick(1);
    chk("wd_at_limit", 64'(bus.protocol_err), 64'(1));
    chk("wd_still_waiting", 64'(bus.req_ready), 64'(0));
    force_busy = 1'b0;
    tick(3);
    chk("wd_sticky", 64'(bus.protocol_err), 64'(1));
    drain();
    do_reset();
    chk("wd_cleared_by_rst", 64'(bus.protocol_err), 64'(0));

    // Asynchronous reset in the ISSUE cycle of an Mflo
    w0 = wb_seen;
    accept(MD_MFLO, 32'h0, 32'h0, 5'd3, a0);
    tick(1);
    chk("pre_rst_issue", 64'(bus.md_op), 64'(MD_MFLO));
    #1 rst_n = 1'b0;
    #1;
    chk("rst_async_md_op", 64'(bus.md_op), 64'(MD_NONE));
    chk("rst_async_wb", 64'(bus.wb_valid), 64'(0));
    #1 rst_n = 1'b1;
    tick(1);
    chk("post_rst_ready", 64'(bus.req_ready), 64'(1));
    chk("post_rst_no_wb", 64'(wb_seen), 64'(w0));

    // Randomized traffic with occasional flushes and MD_NONE requests
    for (int i = 0; i < 60; i++) begin
      if ($urandom_range(0, 9) == 0 && bus.req_ready) begin
        n0 = issue_log.size();
        bus.req_valid = 1'b1; bus.req_op = MD_NONE;
        tick(1);
        bus.req_valid = 1'b0;
        chk("none_ignored", 64'(bus.req_ready), 64'(1));
        tick(1);
        chk("none_no_issue", 64'(issue_log.size()), 64'(n0));
      end
      op = md_op_e'(4'($urandom_range(1, 8)));
      rs = $urandom();
      rt = $urandom();
      if ($urandom_range(0, 1) == 0) rt = 32'($urandom_range(1, 20));
      if (rt == 32'h0) rt = 32'h1;
      send(op, rs, rt, 5'($urandom_range(0, 31)), ($urandom_range(0, 7) == 0), a0);
      tick($urandom_range(0, 2));
    end
    drain();
    chk("rand_perr", 64'(bus.protocol_err), 64'(0));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL global_timeout: simulation did not complete at time %0t", $time);
    $fatal(1, "timeout");
  end

endmodule
